core_apb_bridge: RTL and testbench



---
 rtl/core_apb_bridge_pkg.sv | 19 +
 rtl/core_apb_bridge.sv | 140 ++++++++++++++
 tb/tb_core_apb_bridge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/core_apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB bridge.
package core_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Read data returned when a transfer is killed by the PREADY timeout.
  localparam logic [31:0] TIMEOUT_ERR_RDATA = 32'h0;

  // Counter must be able to hold the value TIMEOUT_CYCLES itself.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/core_apb_bridge.sv
// Core data-bus (req/gnt/rvalid) to APB3 master bridge, one transfer in flight,
// with a PREADY timeout that terminates hung transfers with an error response.
module core_apb_bridge
  import core_apb_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TO_LIMIT = CW'(TIMEOUT_CYCLES);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [3:0]                pstrb_q, pstrb_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      gnt;

  // Accept a new request whenever no transfer is on the APB side.
  assign gnt     = data_req_i & ((state_q == IDLE) | (state_q == RESP));
  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, request capture, response capture and timeout counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE, RESP: begin
        if (gnt) begin
          state_d  = SETUP;
          paddr_d  = data_addr_i;
          pwdata_d = data_wdata_i;
          pwrite_d = data_we_i;
          pstrb_d  = data_we_i ? data_be_i : 4'b0000;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // A ready on the expiry cycle still counts as a normal completion.
        if (pready_i) begin
          state_d = RESP;
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = pslverr_i;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            state_d = RESP;
            rdata_d = TIMEOUT_ERR_RDATA;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) | (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= 4'b0000;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pwrite_o      = pwrite_q;
  assign pstrb_o       = pstrb_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;

endmodule

// File: tb/tb_core_apb_bridge.sv
// Directed bench for core_apb_bridge with a response scoreboard and a
// configurable APB slave (wait states, hang, error).
module tb_core_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, gnt, we, rvalid, err;
  logic [3:0]  be, pstrb;
  logic [31:0] addr, wdata, rdata, paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  always #5 clk = ~clk;

  core_apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req), .data_gnt_o(gnt), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .pstrb_o(pstrb),
    .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // APB slave model: ready after ws wait states unless hung.
  int          ws = 0;
  int          acc_cnt = 0;
  logic        hang = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;

  always @(posedge clk) acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
  assign pready  = psel & penable & !hang & (acc_cnt >= ws);
  assign prdata  = slv_rdata;
  assign pslverr = slv_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic e);
    rsp_t r;
    r.rdata = rd;
    r.err   = e;
    sb.push_back(r);
  endtask

  task automatic pop_chk(input string tag);
    rsp_t r;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(rvalid), 32'h0);
    end else begin
      r = sb.pop_front();
      chk({tag, "_rdata"}, rdata, r.rdata);
      chk({tag, "_err"}, 32'(err), 32'(r.err));
    end
  endtask

  // One complete transfer; checks grant, SETUP phase, APB stability over
  // every ACCESS cycle, ACCESS count, response latency and response data.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat, input int exp_acc);
    int lat  = 0;
    int nacc = 0;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd; be = b;
    #1;
    chk({tag, "_gnt"}, 32'(gnt), 32'h1);
    push_exp(exp_rd, exp_err);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; be = 4'hF;
      end
      @(negedge clk);
      if (k == 1) chk({tag, "_setup"}, {30'h0, psel, penable}, 32'h2);
      if (rvalid) begin
        lat = k;
        break;
      end
      if (psel && penable) begin
        nacc++;
        chk({tag, "_paddr"}, paddr, a);
        chk({tag, "_pwdata"}, pwdata, wd);
        chk({tag, "_ctrl"}, {27'h0, pwrite, pstrb}, {27'h0, w, (w ? b : 4'h0)});
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_naccess"}, 32'(nacc), 32'(exp_acc));
    chk({tag, "_psel_at_resp"}, {30'h0, psel, penable}, 32'h0);
    pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {26'h0, psel, penable, pwrite, rvalid, err, gnt}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_pstrb", 32'(pstrb), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // Zero-wait read
    ws = 0; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
    xfer("rd0", 1'b0, 32'h1A10_0008, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 3, 1);
    chk("rd0_hold_rdata", rdata, 32'hCAFE_F00D);

    // Write, 3 wait states: ready lands on the cycle the counter would expire
    ws = 3; slv_rdata = 32'hFFFF_FFFF;
    xfer("wr0", 1'b1, 32'h1A10_1000, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 6, 4);

    // Read with slave error
    ws = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b1;
    xfer("rd_slverr", 1'b0, 32'h1A10_0010, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 3, 1);
    slv_err = 1'b0;

    // Hung slave: exactly 4 ACCESS cycles then error response
    hang = 1'b1; slv_rdata = 32'h5555_5555;
    xfer("timeout", 1'b0, 32'h1A10_0020, 32'h0, 4'hF, 32'h0, 1'b1, 6, 4);
    hang = 1'b0;

    // Normal read after the timeout
    ws = 1; slv_rdata = 32'h0BAD_CAFE;
    xfer("rd_after_to", 1'b0, 32'h1A10_0024, 32'h0, 4'hF, 32'h0BAD_CAFE, 1'b0, 4, 2);

    // Back-to-back reads with req held high
    ws = 0; slv_rdata = 32'hAAAA_0001;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h1A10_0100; be = 4'hF;
    #1 chk("b2b_gnt0", 32'(gnt), 32'h1);
    push_exp(32'hAAAA_0001, 1'b0);
    @(posedge clk); #1 addr = 32'h1A10_0104;
    @(negedge clk);
    chk("b2b_setup0", {29'h0, gnt, psel, penable}, 32'h2);
    @(negedge clk);
    chk("b2b_access0", {29'h0, gnt, psel, penable}, 32'h3);
    @(negedge clk);
    chk("b2b_rvalid_gnt", {30'h0, rvalid, gnt}, 32'h3);
    pop_chk("b2b0");
    push_exp(32'hBBBB_0002, 1'b0);
    slv_rdata = 32'hBBBB_0002;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("b2b_setup1", {29'h0, rvalid, psel, penable}, 32'h2);
    chk("b2b_paddr1", paddr, 32'h1A10_0104);
    @(negedge clk);
    chk("b2b_access1", {30'h0, psel, penable}, 32'h3);
    @(negedge clk);
    chk("b2b_rvalid1", 32'(rvalid), 32'h1);
    pop_chk("b2b1");

    // Reset during ACCESS abandons the transfer
    hang = 1'b1;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h1A10_0200;
    #1 chk("rstacc_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstacc_in_access", {30'h0, psel, penable}, 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstacc_after", {29'h0, psel, penable, rvalid}, 32'h0);
    rst_n = 1'b1; hang = 1'b0;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid || psel) quiet++;
    end
    chk("rstacc_quiet", 32'(quiet), 32'h0);

    ws = 0; slv_rdata = 32'h7777_8888;
    xfer("rd_after_rst", 1'b0, 32'h1A10_0300, 32'h0, 4'hF, 32'h7777_8888, 1'b0, 3, 1);

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
